// File: rtl/decoder_2x4_stream_pkg.sv
// Shared widths and the 2-to-4 decode function
// for the streaming line decoder.
package decoder_2x4_stream_pkg;

  localparam int CODE_W = 2;
  localparam int LINE_W = 4;

  function automatic logic [LINE_W-1:0] onehot_of(
    input logic [CODE_W-1:0] code,
    input logic              en
  );
    logic [LINE_W-1:0] one;
    one = LINE_W'(1);
    return en ? (one << code) : '0;
  endfunction

endpackage

// File: rtl/decoder_2x4_stream_skid_buf2.sv
// Generic 2-entry FIFO-ordered valid/ready buffer.
// in_ready is a function of registered state only.
module skid_buf2 #(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_q [2];
  logic         head_q;
  logic         tail_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         init_q;
  logic         push;
  logic         pop;

  // init_q keeps the input closed until the first edge after reset release
  assign in_ready  = init_q && (cnt_q < 2'(DEPTH));
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + 2'd1;
      pop && !push: cnt_d = cnt_q - 2'd1;
      default:      cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
      init_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      cnt_q  <= cnt_d;
      if (push) begin
        mem_q[tail_q] <= in_data;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

endmodule

// File: rtl/decoder_2x4_stream.sv
// Registered 2-to-4 decoder with valid/ready stream,
// 2-entry output buffer and saturating symbol count.
module decoder_2x4_stream
  import decoder_2x4_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_onehot,
  output logic [1:0]       out_code,
  output logic [CNT_W-1:0] sym_count
);

  localparam int W = LINE_W + CODE_W;

  logic [W-1:0]     in_data;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] sym_q;
  logic [CNT_W-1:0] sym_d;

  // Decode happens before storage so the buffer holds final lines
  assign in_data = {onehot_of(in_code, in_en), in_code};

  skid_buf2 #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_onehot = out_data[W-1:CODE_W];
  assign out_code   = out_data[CODE_W-1:0];
  assign sym_count  = sym_q;

  always_comb begin
    sym_d = sym_q;
    if (out_valid && out_ready && (sym_q != '1)) begin
      sym_d = sym_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q <= '0;
    end else begin
      sym_q <= sym_d;
    end
  end

endmodule

// File: tb/tb_decoder_2x4_stream.sv
// Directed bench for decoder_2x4_stream (CNT_W=3):
// reset, sweep, enable, backpressure, push/pop, saturation.
module tb_decoder_2x4_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_onehot;
  logic [1:0] out_code;
  logic [2:0] sym_count;

  int n_pass;
  int n_total;

  decoder_2x4_stream #(
    .DEPTH (2),
    .CNT_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_code   (out_code),
    .sym_count  (sym_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh_tab [4];
    logic [1:0] pp_codes [6];
    oh_tab   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    pp_codes = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    n_pass   = 0;
    n_total  = 0;

    // Reset held with in_valid asserted
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'd1;
    in_en     = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_onehot", 8'(out_onehot), 8'h0);
    chk("rst_code", 8'(out_code), 8'd0);
    chk("rst_sym", 8'(sym_count), 8'd0);
    rst_n = 1'b1;
    step();
    chk("rel_nothing_captured", 8'(out_valid), 8'd0);
    chk("rel_in_ready", 8'(in_ready), 8'd1);
    in_valid = 1'b0;

    // Sweep codes 0..3, enabled
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_code  = 2'(c);
      in_en    = 1'b1;
      step();
      chk($sformatf("sweep_valid_%0d", c), 8'(out_valid), 8'd1);
      chk($sformatf("sweep_onehot_%0d", c), 8'(out_onehot),
          8'(oh_tab[c]));
      chk($sformatf("sweep_code_%0d", c), 8'(out_code), 8'(c));
    end
    in_valid = 1'b0;
    in_code  = 2'bxx;
    step();
    chk("sweep_drained", 8'(out_valid), 8'd0);
    chk("sweep_sym", 8'(sym_count), 8'd4);

    // Disabled symbol
    in_valid = 1'b1;
    in_code  = 2'd2;
    in_en    = 1'b0;
    step();
    chk("en0_valid", 8'(out_valid), 8'd1);
    chk("en0_onehot", 8'(out_onehot), 8'h0);
    chk("en0_code", 8'(out_code), 8'd2);
    in_valid = 1'b0;
    step();
    chk("en0_sym", 8'(sym_count), 8'd5);

    // Reset between sections
    rst_n = 1'b0;
    #1;
    chk("rst2_sym", 8'(sym_count), 8'd0);
    rst_n = 1'b1;
    step();

    // Backpressure: 3, 1, 0
    out_ready = 1'b0;
    in_en     = 1'b1;
    in_valid  = 1'b1;
    in_code   = 2'd3;
    step();
    chk("bp_first", 8'(out_onehot), 8'h8);
    in_code = 2'd1;
    step();
    chk("bp_full_ready", 8'(in_ready), 8'd0);
    in_code = 2'd0;
    step();
    chk("bp_third_ready", 8'(in_ready), 8'd0);
    chk("bp_hold_onehot", 8'(out_onehot), 8'h8);
    chk("bp_hold_code", 8'(out_code), 8'd3);
    out_ready = 1'b1;
    step();
    chk("bp_out2", 8'(out_onehot), 8'h2);
    chk("bp_ready_again", 8'(in_ready), 8'd1);
    step();
    chk("bp_out3", 8'(out_onehot), 8'h1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 8'(out_valid), 8'd0);
    chk("bp_sym", 8'(sym_count), 8'd3);

    // Simultaneous push/pop at count=1
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'd0;
    step();
    chk("pp_prime", 8'(out_onehot), 8'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_code = pp_codes[i];
      step();
      chk($sformatf("pp_ready_%0d", i), 8'(in_ready), 8'd1);
      chk($sformatf("pp_onehot_%0d", i), 8'(out_onehot),
          8'(oh_tab[pp_codes[i]]));
    end
    in_valid = 1'b0;
    step();
    chk("pp_drained", 8'(out_valid), 8'd0);
    chk("sat_sym", 8'(sym_count), 8'd7);

    // Mid-operation reset with buffer full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 2'd2;
    step();
    in_code = 2'd3;
    step();
    chk("mid_full", 8'(in_ready), 8'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 8'(out_valid), 8'd0);
    chk("mid_onehot", 8'(out_onehot), 8'h0);
    chk("mid_sym", 8'(sym_count), 8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_release_empty", 8'(out_valid), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
